// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock FIFO.
//   level_width(size)  : width of a counter that can hold 0..size
//   ptr_inc(ptr, size) : pointer increment that wraps from size-1 to 0
//                        (compare-and-reset, so depth need not be 2^n)
//   thresh_ok(...)     : legality check for depth and the two thresholds
package fifo_pkg;

  function automatic int level_width(input int size);
    return $clog2(size + 1);
  endfunction

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned size);
    return (ptr == size - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

  function automatic bit thresh_ok(input int size, input int afThresh, input int aeThresh);
    return (size >= 2) && (afThresh >= 1) && (afThresh <= size) &&
           (aeThresh >= 0) && (aeThresh <= size - 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM, BITS x SIZE, for the single-clock FIFO.
// One synchronous write port and one registered read port; the read
// register only updates when rdEn_i is high, so it holds its last value.
// Ports:
//   clk_i            clock
//   rstN_i           synchronous active-low reset (read register only)
//   wrEn_i/wrAddr_i/wrData_i   write port
//   rdEn_i/rdAddr_i  read request and address
//   rdData_o         registered read data
module fifo_mem #(
  parameter int BITS = 32,
  parameter int SIZE = 16,
  parameter int AW   = $clog2(SIZE)
) (
  input  logic            clk_i,
  input  logic            rstN_i,
  input  logic            wrEn_i,
  input  logic [AW-1:0]   wrAddr_i,
  input  logic [BITS-1:0] wrData_i,
  input  logic            rdEn_i,
  input  logic [AW-1:0]   rdAddr_i,
  output logic [BITS-1:0] rdData_o
);

  logic [BITS-1:0] mem_q [SIZE];
  logic [BITS-1:0] rdData_q;

  // Storage array is deliberately not reset; the FIFO pointers define validity.
  always_ff @(posedge clk_i) begin
    if (wrEn_i) begin
      mem_q[wrAddr_i] <= wrData_i;
    end
  end

  // Read register is reset so the FIFO output starts at zero.
  always_ff @(posedge clk_i) begin
    if (!rstN_i) begin
      rdData_q <= '0;
    end else if (rdEn_i) begin
      rdData_q <= mem_q[rdAddr_i];
    end
  end

  assign rdData_o = rdData_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock parameterised FIFO with programmable almost-full/almost-empty
// thresholds, fill-level output, synchronous flush and sticky
// overflow/underflow flags. Depth may be any integer >= 2.
// Compile-time option: define SYNC_FIFO_FWFT_EN for first-word-fall-through.
// Ports:
//   clk, rst_n (sync, active-low)     clock and reset
//   p_clear                           synchronous flush (below reset in priority)
//   p_write_en/p_write_data           write request and data
//   p_write_full/p_write_almost_full  registered write-side flags
//   p_read_en/p_read_data             pop request and read data
//   p_read_empty/p_read_almost_empty  registered read-side flags
//   p_level                           current word count
//   p_overflow/p_underflow            sticky rejected-write/read flags
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int BITS      = 32,
  parameter int SIZE      = 16,
  parameter int AF_THRESH = SIZE - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         p_clear,
  input  logic                         p_write_en,
  input  logic [BITS-1:0]              p_write_data,
  output logic                         p_write_full,
  output logic                         p_write_almost_full,
  input  logic                         p_read_en,
  output logic [BITS-1:0]              p_read_data,
  output logic                         p_read_empty,
  output logic                         p_read_almost_empty,
  output logic [level_width(SIZE)-1:0] p_level,
  output logic                         p_overflow,
  output logic                         p_underflow
);

  localparam int LW = level_width(SIZE);
  localparam int PW = $clog2(SIZE);

  if (!thresh_ok(SIZE, AF_THRESH, AE_THRESH)) begin : gBadParams
    $fatal(1, "sync_fifo: illegal SIZE/AF_THRESH/AE_THRESH combination");
  end

  logic [PW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          aFull_q, aFull_d, aEmpty_q, aEmpty_d;
  logic          overflow_q, overflow_d, underflow_q, underflow_d;
  logic          wrAccept, rdAccept, ramRe, memWe, memRe;

  assign wrAccept = p_write_en && !full_q;
  assign rdAccept = p_read_en && !empty_q;

`ifdef SYNC_FIFO_FWFT_EN
  // The RAM read register doubles as the output holding register; outValid
  // says whether it currently holds the head word. The RAM is refilled
  // whenever it has words and the holder is free or being popped.
  logic          outValid_q, outValid_d;
  logic [LW-1:0] ramCount;
  assign ramCount = level_q - LW'(outValid_q);
  assign ramRe    = (ramCount != '0) && (!outValid_q || rdAccept);
`else
  assign ramRe = rdAccept;
`endif

  // Memory is untouched by reset and flush so discarded data is simply orphaned.
  assign memWe = rst_n && !p_clear && wrAccept;
  assign memRe = rst_n && !p_clear && ramRe;

  // Next-state for pointers, level, sticky flags, then flags from the new level.
  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
`ifdef SYNC_FIFO_FWFT_EN
    outValid_d  = outValid_q;
`endif
    if (p_clear) begin
      wrPtr_d     = '0;
      rdPtr_d     = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
      outValid_d  = 1'b0;
`endif
    end else begin
      if (wrAccept) begin
        wrPtr_d = PW'(ptr_inc(32'(wrPtr_q), SIZE));
      end
      if (ramRe) begin
        rdPtr_d = PW'(ptr_inc(32'(rdPtr_q), SIZE));
      end
      case ({wrAccept, rdAccept})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (p_write_en && full_q) begin
        overflow_d = 1'b1;
      end
      if (p_read_en && empty_q) begin
        underflow_d = 1'b1;
      end
`ifdef SYNC_FIFO_FWFT_EN
      if (ramRe) begin
        outValid_d = 1'b1;
      end else if (rdAccept) begin
        outValid_d = 1'b0;
      end
`endif
    end
    full_d   = (level_d == LW'(SIZE));
    aFull_d  = (level_d >= LW'(AF_THRESH));
    aEmpty_d = (level_d <= LW'(AE_THRESH));
`ifdef SYNC_FIFO_FWFT_EN
    // With fall-through, empty means nothing is presented on the output yet.
    empty_d  = !outValid_d;
`else
    empty_d  = (level_d == '0);
`endif
  end

  // State registers; reset takes priority over everything including flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      level_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      aFull_q     <= 1'b0;
      aEmpty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
      outValid_q  <= 1'b0;
`endif
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      level_q     <= level_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      aFull_q     <= aFull_d;
      aEmpty_q    <= aEmpty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
`ifdef SYNC_FIFO_FWFT_EN
      outValid_q  <= outValid_d;
`endif
    end
  end

  fifo_mem #(
    .BITS(BITS),
    .SIZE(SIZE),
    .AW  (PW)
  ) uMem (
    .clk_i   (clk),
    .rstN_i  (rst_n),
    .wrEn_i  (memWe),
    .wrAddr_i(wrPtr_q),
    .wrData_i(p_write_data),
    .rdEn_i  (memRe),
    .rdAddr_i(rdPtr_q),
    .rdData_o(p_read_data)
  );

  assign p_write_full        = full_q;
  assign p_write_almost_full = aFull_q;
  assign p_read_empty        = empty_q;
  assign p_read_almost_empty = aEmpty_q;
  assign p_level             = level_q;
  assign p_overflow          = overflow_q;
  assign p_underflow         = underflow_q;

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parameterised FIFO: the same-clock counterpart of the dual-clock async FIFO, used wherever producer and consumer share one clock. Adds programmable almost-full/almost-empty thresholds, a fill-level output, synchronous flush, and sticky overflow/underflow flags. Depth need not be a power of two. First-word-fall-through read is a compile-time option.

## Interface
- BITS, 32: width of each entry.
- SIZE, 16: number of entries, any integer ≥ 2.
- AF_THRESH, SIZE-2: almost-full threshold, legal range 1..SIZE.
- AE_THRESH, 2: almost-empty threshold, legal range 0..SIZE-1.
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset, **synchronous, active-low**.
- p_clear  in  1  synchronous flush.
- p_write_en  in  1  write request.
- p_write_data  in  BITS  data to write.
- p_write_full  out  1  FIFO full.
- p_write_almost_full  out  1  level ≥ AF_THRESH.
- p_read_en  in  1  read request (pop).
- p_read_data  out  BITS  read data.
- p_read_empty  out  1  FIFO empty.
- p_read_almost_empty  out  1  level ≤ AE_THRESH.
- p_level  out  $clog2(SIZE+1)  current word count.
- p_overflow  out  1  sticky: a write was rejected.
- p_underflow  out  1  sticky: a read was rejected.

## Operation
- **Write acceptance.** A write is accepted iff p_write_en && !p_write_full. The full flag is the registered value, so a write on a full FIFO is rejected even when a read is accepted in the same cycle.
- **Read acceptance.** A read is accepted iff p_read_en && !p_read_empty. On an empty FIFO, a read is rejected even when a write is accepted in the same cycle.
- **Rejected operations.** A rejected write sets p_overflow; a rejected read sets p_underflow. The memory, pointers and level are unchanged.
- **Pointers.** Write and read pointers are in 0..SIZE-1 and wrap from SIZE-1 to 0 by compare-and-reset, not modulo-2^n.
- **Level update.** Level +1 on an accepted write alone, -1 on an accepted read alone, unchanged when both are accepted. It saturates at 0 and SIZE by construction.
- **Flags.** All flags are registered and computed from the next level:
  - full = (level == SIZE)
  - empty = (level == 0)
  - almost_full = (level ≥ AF_THRESH)
  - almost_empty = (level ≤ AE_THRESH)
- **Flush.** p_clear has priority over read and write in the same cycle. It zeroes both pointers and the level, clears p_overflow and p_underflow, and leaves memory contents and p_read_data unchanged.
- **Reset.** Reset has priority over p_clear. Reset mid-operation discards all contents.
- **Reset values.** p_write_full=0, p_read_empty=1, p_write_almost_full=0, p_read_almost_empty=1, p_level=0, p_read_data=0, p_overflow=0, p_underflow=0.
- **Parameter checks.** Illegal threshold values cause `$fatal` at elaboration.

## Timing
- **Standard read.** A read accepted at edge k presents its data on p_read_data after edge k (one-cycle latency). The data holds until the next accepted read.
- **Write to empty.** A write accepted at edge k deasserts p_read_empty after edge k. A read may be issued in cycle k+1.
- **Read of last word.** A read of the last word at edge k asserts p_read_empty after edge k.
- **Level and flags.** p_level and all flags reflect the operations at edge k immediately after edge k.
- **Flush.** p_clear sampled at edge k gives empty=1 and level=0 after edge k.
- **Throughput.** One write and one read per cycle, with no bubbles.

## Configuration
- **SYNC_FIFO_FWFT_EN undefined:** standard read timing as above.
- **SYNC_FIFO_FWFT_EN defined:** first-word-fall-through.
  - p_read_data shows the head word whenever p_read_empty=0; p_read_en pops it.
  - An output holding register is added.
  - A write to an empty FIFO at edge k presents its data and deasserts empty after edge k+1.
  - p_level counts the held word. Total capacity stays SIZE.
  - Flags are still derived from p_level.
  - p_clear also invalidates the holding register.

## Structure
- **Package fifo_pkg** holds:
  - the function `level_width(size)`, which returns $clog2(size+1);
  - the pointer-increment-with-wrap function;
  - the threshold-range check function.
- **Sub-module fifo_mem:** simple dual-port RAM, BITS×SIZE, one synchronous write port and one registered read port. sync_fifo holds the pointers, level and flag logic.

## Test plan
- **Reset:** hold rst_n low 3 cycles with p_write_en=1 and p_write_data=0xDEAD_BEEF -> empty=1, full=0, level=0, overflow=0; after release, the first read attempt underflows.
- **Fill and drain (SIZE=16):** write 0..15 -> almost_full asserts after the 14th write and full after the 16th. A 17th write is rejected and sets p_overflow=1. Reading 16 words returns 0..15 in order; empty asserts after the last read.
- **Steady state:** fill to level 8, then issue simultaneous read and write every cycle for 100 cycles with incrementing data -> level stays 8, flags are constant, and the read stream is contiguous.
- **Non-power-of-two depth (SIZE=5):** 40 random interleaved reads and writes across several wraps -> order is preserved, full occurs at level 5, and no spurious flags appear.
- **Flush and underflow:**
  - a read on empty sets p_underflow=1 and leaves p_read_data unchanged;
  - at level 7, asserting p_clear together with p_write_en and p_read_en gives level=0, empty=1, overflow=0 and underflow=0 one edge later.
- **FWFT build:** write 0xA5A5_0001 to an empty FIFO -> empty deasserts two edges later, p_read_data=0xA5A5_0001 with no read issued, and p_read_en pops it.
